// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between the datapath and the program-counter controller.
// The datapath drives the hazard and control-flow requests and receives the fetch address and status.
interface pc_ctrl_if;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        fault;
    logic [31:0] instr_count;

    modport master (
        output stall, imem_ready, branch_taken, branch_offset,
               jump, jump_target, jr, jr_addr,
        input  pc_out, pc_valid, fault, instr_count
    );

    modport slave (
        input  stall, imem_ready, branch_taken, branch_offset,
               jump, jump_target, jr, jr_addr,
        output pc_out, pc_valid, fault, instr_count
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential/branch/jump/register-jump next-PC selection,
// with hazard stalls, a sticky misaligned-target fault and a retired-advance counter.
module pc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      reset,
    pc_ctrl_if.slave  bus
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] STALL = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] count_q, count_nxt;
    logic        valid_q, fault_q;

    logic [31:0] pc_plus4, branch_tgt, jump_tgt, target;
    logic        jr_misaligned;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_tgt    = pc_plus4 + (bus.branch_offset << 2);
        jump_tgt      = {pc_plus4[31:28], bus.jump_target, 2'b00};
        jr_misaligned = bus.jr && (bus.jr_addr[1:0] != 2'b00);

        if (bus.jr)                target = bus.jr_addr;
        else if (bus.jump)         target = jump_tgt;
        else if (bus.branch_taken) target = branch_tgt;
        else                       target = pc_plus4;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt = state;
        pc_nxt    = pc_q;
        count_nxt = count_q;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (bus.stall) begin
                    state_nxt = STALL;
                end else if (bus.imem_ready) begin
                    if (jr_misaligned) begin
                        state_nxt = FAULT;
                    end else begin
                        pc_nxt    = target;
                        count_nxt = count_q + 32'd1;
                    end
                end
            end
            STALL: if (!bus.stall) state_nxt = FETCH;
            FAULT: state_nxt = FAULT;
            default: state_nxt = BOOT;
        endcase
    end

    // Status outputs are flopped from the next state so no input reaches an output combinationally.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            count_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            count_q <= count_nxt;
            valid_q <= (state_nxt == FETCH);
            fault_q <= (state_nxt == FAULT);
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.pc_valid    = valid_q;
    assign bus.fault       = fault_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: each driven cycle queues hand-derived expected outputs,
// which are popped and compared one cycle later (or immediately for asynchronous reset).
module tb_pc_ctrl;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
        logic [31:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pc_ctrl_if bus ();

    pc_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic v,
                        input logic f, input logic [31:0] c);
        exp_t e;
        e.tag = tag; e.pc = pc; e.valid = v; e.fault = f; e.count = c;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".pc"},    bus.pc_out,              e.pc);
            check({e.tag, ".valid"}, {31'd0, bus.pc_valid},   {31'd0, e.valid});
            check({e.tag, ".fault"}, {31'd0, bus.fault},      {31'd0, e.fault});
            check({e.tag, ".count"}, bus.instr_count,         e.count);
        end
    endtask

    task automatic drive(input logic st, input logic rdy, input logic br, input logic [31:0] off,
                         input logic jmp, input logic [25:0] tgt, input logic jrr,
                         input logic [31:0] addr);
        bus.stall = st; bus.imem_ready = rdy; bus.branch_taken = br; bus.branch_offset = off;
        bus.jump = jmp; bus.jump_target = tgt; bus.jr = jrr; bus.jr_addr = addr;
    endtask

    // One clock: drive controls, queue the expectation, sample 1 ns after the edge.
    task automatic step(input string tag, input logic st, input logic rdy, input logic br,
                        input logic [31:0] off, input logic jmp, input logic [25:0] tgt,
                        input logic jrr, input logic [31:0] addr, input logic [31:0] e_pc,
                        input logic e_v, input logic e_f, input logic [31:0] e_c);
        drive(st, rdy, br, off, jmp, tgt, jrr, addr);
        push(tag, e_pc, e_v, e_f, e_c);
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic seq(input string tag, input logic [31:0] e_pc, input logic [31:0] e_c);
        step(tag, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, e_pc, 1'b1, 1'b0, e_c);
    endtask

    task automatic jr_to(input string tag, input logic [31:0] addr, input logic [31:0] e_c);
        step(tag, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, addr, addr, 1'b1, 1'b0, e_c);
    endtask

    // Asserts reset mid-cycle with busy inputs, checks before the next edge and while held.
    task automatic pulse_reset(input string tag);
        drive(1'b0, 1'b1, 1'b1, 32'd5, 1'b1, 26'h3FF, 1'b0, 32'd0);
        #3 reset = 1'b1;
        #1;
        push({tag, "_async"}, 32'h0, 1'b0, 1'b0, 32'd0);
        observe();
        @(posedge clk);
        #1;
        push({tag, "_held"}, 32'h0, 1'b0, 1'b0, 32'd0);
        observe();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0);
        #12;
        push("reset", 32'h0, 1'b0, 1'b0, 32'd0);
        observe();
        @(posedge clk);
        #1 reset = 1'b0;

        // Boot cycle, then two sequential advances
        seq("boot", 32'h0, 32'd0);
        seq("seq1", 32'h4, 32'd1);
        seq("seq2", 32'h8, 32'd2);

        // Jump to 0x100, jump beats branch, branch alone with negative offset
        step("jmp100", 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h40, 1'b0, 32'd0, 32'h100, 1'b1, 1'b0, 32'd3);
        step("jmp_over_br", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'h40, 1'b0, 32'd0,
             32'h100, 1'b1, 1'b0, 32'd4);
        step("br_neg", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 32'd0,
             32'hFC, 1'b1, 1'b0, 32'd5);
        seq("seq_fc", 32'h100, 32'd6);

        // Memory not ready: hold, controls ignored
        step("not_ready", 1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 26'd0, 1'b0, 32'd0, 32'h100, 1'b1, 1'b0, 32'd6);

        // Stall at 0x20 for three cycles with jump asserted, exit cycle does not advance
        jr_to("jr20", 32'h20, 32'd7);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 26'h3FF, 1'b0, 32'd0,
                 32'h20, 1'b0, 1'b0, 32'd7);
        step("stall_exit", 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h3FF, 1'b0, 32'd0,
             32'h20, 1'b1, 1'b0, 32'd7);
        seq("post_stall", 32'h24, 32'd8);

        // Jump keeps upper nibble of pc+4; positive branch; jr beats jump and branch
        jr_to("jr_1ffc", 32'h1FFF_FFFC, 32'd9);
        step("jmp_nibble", 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h1, 1'b0, 32'd0,
             32'h2000_0004, 1'b1, 1'b0, 32'd10);
        step("br_pos", 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 26'd0, 1'b0, 32'd0,
             32'h2000_0014, 1'b1, 1'b0, 32'd11);
        step("jr_prio", 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 26'h5, 1'b1, 32'h100,
             32'h100, 1'b1, 1'b0, 32'd12);

        // Misaligned jr: fault, frozen until reset
        step("jr_bad", 1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 26'h5, 1'b1, 32'h202,
             32'h100, 1'b0, 1'b1, 32'd12);
        for (int i = 0; i < 2; i++)
            step($sformatf("fault_hold%0d", i), 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h400,
                 32'h100, 1'b0, 1'b1, 32'd12);
        pulse_reset("rst_fault");

        // Wrap-around on branch and sequential, then reset mid-operation
        seq("boot2", 32'h0, 32'd0);
        jr_to("jr_fff8", 32'hFFFF_FFF8, 32'd1);
        step("br_wrap", 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 26'd0, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 32'd2);
        jr_to("jr_fffc", 32'hFFFF_FFFC, 32'd3);
        seq("seq_wrap", 32'h0, 32'd4);
        seq("seq_after_wrap", 32'h4, 32'd5);
        pulse_reset("rst_fetch");

        // Reset while in STALL
        seq("boot3", 32'h0, 32'd0);
        seq("seq3", 32'h4, 32'd1);
        step("stall_b", 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 32'h4, 1'b0, 1'b0, 32'd1);
        pulse_reset("rst_stall");
        seq("boot4", 32'h0, 32'd0);
        seq("seq4", 32'h4, 32'd1);

        check("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port stall  input  1  hazard hold request from the datapath.
REQ-005 SHALL provide port imem_ready  input  1  instruction memory has accepted the current pc_out.
REQ-006 SHALL provide port branch_taken  input  1  conditional branch resolved taken.
REQ-007 SHALL provide port branch_offset  input  32  sign-extended word offset.
REQ-008 SHALL provide port jump  input  1  J/JAL request.
REQ-009 SHALL provide port jump_target  input  26  J-format target field.
REQ-010 SHALL provide port jr  input  1  JR/JALR request.
REQ-011 SHALL provide port jr_addr  input  32  register jump address.
REQ-012 SHALL provide port pc_out  output  32  current fetch address (registered).
REQ-013 SHALL provide port pc_valid  output  1  pc_out is a live fetch request (registered).
REQ-014 SHALL provide port fault  output  1  sticky misaligned-target flag (registered).
REQ-015 SHALL provide port instr_count  output  32  count of completed PC advances (registered).

Function
REQ-016 SHALL implement FSM states BOOT, FETCH, STALL, FAULT.
REQ-017 BOOT SHALL last exactly one cycle, then move to FETCH; pc_valid=0 in BOOT, 1 in FETCH.
REQ-018 An advance SHALL occur in FETCH when imem_ready=1 and stall=0; control inputs are sampled only on advance cycles.
REQ-019 Next-PC priority on advance SHALL be jr > jump > branch_taken > sequential.
REQ-020 Sequential: pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-021 Branch: (pc_out+4)+(branch_offset<<2), modulo 2^32, overflow discarded.
REQ-022 Jump: {pc_plus4[31:28], jump_target, 2'b00}.
REQ-023 JR: jr_addr when jr_addr[1:0]==0; otherwise -> FAULT, pc_out unchanged, fault=1, no count increment.
REQ-024 Each advance SHALL increment instr_count by 1 (wraps at 2^32), same cycle as the pc_out update.
REQ-025 FETCH with imem_ready=0 and stall=0: hold pc_out, stay FETCH, pc_valid=1.
REQ-026 FETCH with stall=1: -> STALL next cycle, pc_out held, controls ignored regardless of imem_ready.
REQ-027 STALL: pc_valid=0, pc_out held; stall=0 -> FETCH next cycle, with no advance on the exit cycle.
REQ-028 FAULT: pc_valid=0, pc_out and instr_count frozen, fault=1; exited only by reset.
REQ-029 Combinational paths from inputs to outputs SHALL not exist.

Reset
REQ-030 reset=1 SHALL immediately, without a clock: state=BOOT, pc_out=RESET_VECTOR, pc_valid=0, fault=0, instr_count=0.
REQ-031 Reset asserted mid-operation, including in STALL or FAULT, SHALL abort all state with the same values as REQ-030.
REQ-032 After reset deassertion, the first advance SHALL occur no earlier than the second posedge.

Verification
REQ-033 Reset, then 3 cycles with imem_ready=1 and no controls -> pc_out 0,0(BOOT),4,8; instr_count=2; pc_valid 0 then 1.
REQ-034 pc_out=0x100, branch_taken=1, offset=-2, plus jump=1 with target=0x40 in the same cycle -> pc_out=0x100 (jump wins over branch); repeat with branch alone -> 0xFC.
REQ-035 pc_out=0x100, jr=1, jr_addr=0x202 -> FAULT, fault=1, pc_valid=0, pc_out=0x100; stays until reset.
REQ-036 stall=1 for 3 cycles at pc_out=0x20 with jump asserted -> pc_out stays 0x20, pc_valid=0; after stall drops, next advance gives 0x24.
REQ-037 pc_out=0xFFFF_FFFC, sequential advance -> 0x0000_0000; assert reset asynchronously mid-cycle -> outputs equal RESET_VECTOR/0 before the next edge.
